seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider that produces the quotient/remainder pair the ALU drives onto Z_High/Z_Low for its divide opcode (Z_High = quotient, Z_Low = remainder).
- Sits beside the ALU in the datapath. The ALU asserts start with A/B and waits for ready before capturing the results.
- Uses a radix-2 restoring algorithm on magnitudes, then applies a sign-fixup step.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SIGNED, 1, 1 = two's-complement division, 0 = unsigned division.

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled only in IDLE
- A  input  WIDTH  dividend
- B  input  WIDTH  divisor
- busy  output  1  high while a division is in progress
- ready  output  1  one-cycle pulse; results are valid from this cycle on
- div_by_zero  output  1  set with ready when B was 0; held until the next accepted start
- Z_High  output  WIDTH  quotient
- Z_Low  output  WIDTH  remainder

Behaviour:
- Reset: asynchronous and active-low. When clr_n is low:
  - state = IDLE
  - busy, ready and div_by_zero = 0
  - Z_High and Z_Low = 0
  - internal registers are cleared.
- Reset asserted mid-operation aborts the division with no ready pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE, on the edge where start = 1 (edge k):
  - latch the sign of A, the sign of B and |A|, |B| (magnitudes are taken only when SIGNED = 1)
  - clear the partial remainder
  - set counter = WIDTH and busy = 1
  - if B == 0: set the dz flag and go to FIX; otherwise go to RUN.
- RUN, one iteration per edge:
  - shift {rem, quo} left by 1
  - trial = rem - |B|, computed WIDTH+1 bits wide
  - if trial is non-negative, rem = trial and quo[0] = 1
  - decrement counter; when the counter reaches 1, go to FIX after this iteration (WIDTH iterations total).
- FIX, one edge:
  - quotient is negated if sign(A) XOR sign(B)
  - remainder takes the sign of the dividend
  - result is written to Z_High/Z_Low
  - busy = 0, ready = 1, go to DONE.
- DONE: ready returns to 0 and the block goes to IDLE. A start seen in DONE is ignored; it must be re-presented in IDLE.
- Latency:
  - normal division: ready is high in the cycle after edge k+WIDTH+1 (33 edges after the start edge for WIDTH = 32)
  - divide-by-zero: ready after edge k+1.
- Divide-by-zero result: Z_High = all ones, Z_Low = A unchanged, div_by_zero = 1.
- Overflow (SIGNED, A = most-negative value, B = -1): Z_High = 0x80000000, Z_Low = 0. No flag is raised; this falls out of the magnitude path.
- start while busy or in DONE is ignored. Operands are not re-sampled, so A and B may change freely after edge k.
- Z_High, Z_Low and div_by_zero hold their last values until the FIX of the next accepted division. div_by_zero clears on the next accepted start.
- ready and busy are never high in the same cycle.

Decomposition:
- Shared package contains:
  - the state enum (IDLE/RUN/FIX/DONE)
  - the default WIDTH
  - DIV0_QUOTIENT, the all-ones constant
  - the ALU divide opcode 4'b0011, so the ALU control and this block agree.
- One natural sub-module: div_step. It is purely combinational and performs a single restoring iteration: it takes rem, quo and divisor, and returns next rem and next quo. The top level holds the FSM, counter and sign logic.

Test Plan:
- Unsigned/signed basic: A=100, B=7 after start. Required: busy for 33 cycles, then ready, Z_High=14, Z_Low=2, div_by_zero=0.
- Negative dividend: A=-100 (0xFFFFFF9C), B=7. Required: Z_High=0xFFFFFFF2 (-14), Z_Low=0xFFFFFFFE (-2).
- Divide by zero: A=0x12345678, B=0. Required: ready 2 edges after start, Z_High=0xFFFFFFFF, Z_Low=0x12345678, div_by_zero=1.
- Overflow: A=0x80000000, B=0xFFFFFFFF. Required: Z_High=0x80000000, Z_Low=0.
- Start while busy:
  - A=50, B=5 started; at cycle 10, pulse start with A=9, B=3 → ignored, result Z_High=10, Z_Low=0.
  - A start in the DONE cycle is also ignored.
- Reset mid-operation: drop clr_n at cycle 15 of a division. Required: busy, ready and outputs go 0 asynchronously; no ready pulse; a new start after release computes 81/9 → Z_High=9, Z_Low=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and the ALU control that drives it.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

  localparam logic [3:0] ALU_OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left and subtract the divisor if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // rem < divisor always holds, so the shifted value minus the divisor fits in WIDTH+1 signed bits.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, divisor};
  assign fits     = ~trial[WIDTH];
  assign rem_next = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: quotient on Z_High, remainder on Z_Low.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Z_High,
  output logic [WIDTH-1:0] Z_Low
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'($signed(DIV0_QUOTIENT));

  div_state_t       state, next_state;
  logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_a_q, neg_quo_q, dz_q;

  logic             sign_a_in, sign_b_in, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a_in = SIGNED && A[WIDTH-1];
  assign sign_b_in = SIGNED && B[WIDTH-1];
  assign mag_a     = sign_a_in ? -A : A;
  assign mag_b     = sign_b_in ? -B : B;
  assign b_zero    = (B == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = b_zero ? FIX : RUN;
      RUN:     if (cnt_q == CNT_W'(1)) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A zero divisor skips RUN, so quo_q carries the raw dividend straight to Z_Low.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      sign_a_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      Z_High      <= '0;
      Z_Low       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_a_q    <= sign_a_in;
            neg_quo_q   <= sign_a_in ^ sign_b_in;
            divisor_q   <= mag_b;
            rem_q       <= '0;
            quo_q       <= b_zero ? A : mag_a;
            cnt_q       <= CNT_W'(WIDTH);
            dz_q        <= b_zero;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          busy        <= 1'b0;
          ready       <= 1'b1;
          div_by_zero <= dz_q;
          if (dz_q) begin
            Z_High <= DIV0_Q;
            Z_Low  <= quo_q;
          end else begin
            Z_High <= neg_quo_q ? -quo_q : quo_q;
            Z_Low  <= sign_a_q ? -rem_q : rem_q;
          end
        end
        DONE: begin
          ready <= 1'b0;
        end
        default: begin
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32, signed): results are checked as ready pulses.
module tb_seq_divider;
  import seq_divider_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          busy_cycles;
    int          c0;
  } exp_t;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [31:0] A, B;
  logic        busy, ready, div_by_zero;
  logic [31:0] Z_High, Z_Low;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .Z_High      (Z_High),
    .Z_Low       (Z_Low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: C-style truncating division, with the zero-divisor and overflow cases.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c0);
    exp_t e;
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    e.c0 = c0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 2; e.busy_cycles = 1;
    end else begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 32'd0;
      end else begin
        e.q = sa / sbv; e.r = sa % sbv;
      end
      e.dz = 1'b0; e.lat = 34; e.busy_cycles = 33;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    A = a;
    B = b;
    start = 1'b1;
    if (expect_result) sb.push_back(model(a, b, cyc));
  endtask

  task automatic waitResult(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) break;
    end
    checkOutput("ready_seen", {31'd0, ready}, 32'd1);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clr_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (ready) begin
        checkOutput("busy_ready_excl", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("spurious_ready", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("quotient", Z_High, mon_e.q);
          checkOutput("remainder", Z_Low, mon_e.r);
          checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
          checkOutput("latency", cyc - mon_e.c0, mon_e.lat);
          checkOutput("busy_cycles", busy_cnt, mon_e.busy_cycles);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    $display("[TB] divide opcode %b", ALU_OP_DIV);
    clr_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_dz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("rst_zhigh", Z_High, 32'd0);
    checkOutput("rst_zlow", Z_Low, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'd100, 32'd7, 1'b1);
    waitResult(60);
    @(negedge clk);
    checkOutput("ready_one_cycle", {31'd0, ready}, 32'd0);

    applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1);
    waitResult(60);
    @(negedge clk);

    applyStimulus(32'h1234_5678, 32'd0, 1'b1);
    waitResult(60);
    @(negedge clk);

    // The next accepted start clears div_by_zero while results hold until FIX.
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    start = 1'b0;
    A = 32'd5;
    B = 32'd5;
    checkOutput("dz_cleared_on_start", {31'd0, div_by_zero}, 32'd0);
    checkOutput("zhigh_held", Z_High, 32'hFFFF_FFFF);
    checkOutput("zlow_held", Z_Low, 32'h1234_5678);
    waitResult(60);
    @(negedge clk);

    // A second start while busy must not disturb the running division.
    applyStimulus(32'd50, 32'd5, 1'b1);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    applyStimulus(32'd9, 32'd3, 1'b0);
    waitResult(60);
    A = 32'd7;
    B = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_start_ignored", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("done_start_no_result", Z_High, 32'd10);

    applyStimulus(32'd7, 32'd100, 1'b1);
    waitResult(60);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
    waitResult(60);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      applyStimulus(ra, rb, 1'b1);
      waitResult(60);
      @(negedge clk);
    end

    // Asynchronous reset mid-division: outputs clear at once and the pending result is dropped.
    applyStimulus(32'd1000, 32'd3, 1'b1);
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    clr_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, ready}, 32'd0);
    checkOutput("abort_zhigh", Z_High, 32'd0);
    checkOutput("abort_zlow", Z_Low, 32'd0);
    checkOutput("abort_pending", sb.size(), 32'd1);
    sb.delete();
    repeat (4) @(negedge clk);
    clr_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_ready", {31'd0, ready}, 32'd0);
    applyStimulus(32'd81, 32'd9, 1'b1);
    waitResult(60);
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
